// File: rtl/alu_issue_wb.sv
// alu_issue_wb: in-order issue queue feeding a combinational ALU, plus a
// single registered writeback slot returning result, branch outcome and tag.
module alu_issue_wb #(
  parameter int XLEN          = 32,
  parameter int OP_BITS       = 8,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4,
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int CNT_W        = PTR_W + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [OP_BITS-1:0]       issue_op_i,
  input  logic [XLEN-1:0]          issue_operand_a_i,
  input  logic [XLEN-1:0]          issue_operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  output logic                     alu_valid_o,
  output logic [OP_BITS-1:0]       alu_op_o,
  output logic [XLEN-1:0]          alu_operand_a_o,
  output logic [XLEN-1:0]          alu_operand_b_o,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_branch_res_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [CNT_W-1:0]         count_o
);

  logic [OP_BITS-1:0]       op_q [DEPTH];
  logic [XLEN-1:0]          a_q  [DEPTH];
  logic [XLEN-1:0]          b_q  [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_q [DEPTH];

  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]          wb_result_q, wb_result_d;
  logic                     wb_branch_q, wb_branch_d;
  logic [TRANS_ID_BITS-1:0] wb_id_q, wb_id_d;

  logic push, pop;

  // Ready looks only at the registered count; a same-cycle pop does not free a slot early.
  assign issue_ready_o = (count_q < CNT_W'(DEPTH));
  assign alu_valid_o   = (count_q != '0);
  assign push = issue_valid_i && issue_ready_o && !flush_i;
  assign pop  = alu_valid_o && (!wb_valid_q || wb_ready_i) && !flush_i;

  // Head entry drives the ALU directly; zeros when the queue is empty.
  always_comb begin
    alu_op_o        = '0;
    alu_operand_a_o = '0;
    alu_operand_b_o = '0;
    if (alu_valid_o) begin
      alu_op_o        = op_q[rd_ptr_q];
      alu_operand_a_o = a_q[rd_ptr_q];
      alu_operand_b_o = b_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and the writeback slot; flush wins over everything.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_branch_d = wb_branch_q;
    wb_id_d     = wb_id_q;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      wb_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        wb_valid_d  = 1'b1;
        wb_result_d = alu_result_i;
        wb_branch_d = alu_branch_res_i;
        wb_id_d     = id_q[rd_ptr_q];
      end else if (wb_valid_q && wb_ready_i) begin
        wb_valid_d = 1'b0;
      end
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  // Control and writeback state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_branch_q <= 1'b0;
      wb_id_q     <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_branch_q <= wb_branch_d;
      wb_id_q     <= wb_id_d;
    end
  end

  // Queue storage written at the tail on each accepted issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        a_q[i]  <= '0;
        b_q[i]  <= '0;
        id_q[i] <= '0;
      end
    end else if (push) begin
      op_q[wr_ptr_q] <= issue_op_i;
      a_q[wr_ptr_q]  <= issue_operand_a_i;
      b_q[wr_ptr_q]  <= issue_operand_b_i;
      id_q[wr_ptr_q] <= issue_trans_id_i;
    end
  end

  assign wb_valid_o      = wb_valid_q;
  assign wb_result_o     = wb_result_q;
  assign wb_branch_res_o = wb_branch_q;
  assign wb_trans_id_o   = wb_id_q;
  assign count_o         = count_q;

endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Issue-side driver and writeback collector for the single-cycle integer ALU. It accepts tagged operations from the issue stage into a DEPTH-entry in-order queue and presents the head entry to the combinational ALU. It captures the ALU result and branch outcome into a registered writeback slot and returns them with their transaction ID under a valid/ready handshake. It sits between issue and the ALU, and between the ALU and the writeback/scoreboard port.

## Interface
- XLEN, 32, operand/result width
- OP_BITS, 8, ALU operation code width (opaque to this block)
- TRANS_ID_BITS, 3, transaction tag width
- DEPTH, 4, queue entries (power of two, ≥2)

- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all queued and pending-writeback operations
- issue_valid_i  in  1  issue operation offered
- issue_ready_o  out  1  queue can accept
- issue_op_i  in  OP_BITS  ALU operation
- issue_operand_a_i  in  XLEN  operand A
- issue_operand_b_i  in  XLEN  operand B
- issue_trans_id_i  in  TRANS_ID_BITS  tag
- alu_valid_o  out  1  head entry present on ALU inputs
- alu_op_o  out  OP_BITS  head operation
- alu_operand_a_o  out  XLEN  head operand A
- alu_operand_b_o  out  XLEN  head operand B
- alu_result_i  in  XLEN  ALU result, combinational from alu_*_o
- alu_branch_res_i  in  1  ALU branch comparison result
- wb_valid_o  out  1  writeback slot holds a result
- wb_ready_i  in  1  consumer accepts writeback
- wb_result_o  out  XLEN  captured result
- wb_branch_res_o  out  1  captured branch result
- wb_trans_id_o  out  TRANS_ID_BITS  tag of captured result
- count_o  out  $clog2(DEPTH)+1  queue occupancy

## Operation
- Queue: circular buffer with read/write pointers and a count; it stores {op, a, b, trans_id}.
- Push occurs when issue_valid_i && issue_ready_o && !flush_i.
- issue_ready_o = (count < DEPTH). It depends on registered count only and is not relieved by a same-cycle pop.
- alu_valid_o = (count != 0). alu_op_o/operands show the head entry combinationally. When the queue is empty they are zero.
- Pop/capture condition: alu_valid_o && (!wb_valid_o || wb_ready_i) && !flush_i. On capture:
  - wb_result_o ← alu_result_i, wb_branch_res_o ← alu_branch_res_i, wb_trans_id_o ← head trans_id, wb_valid_o ← 1.
  - The head is popped.
- Writeback handshake: if wb_ready_i && wb_valid_o and there is no capture, wb_valid_o ← 0.
- Once wb_valid_o is high, wb_* stays stable until the handshake completes.
- Push and pop may occur in the same cycle. In that case count is unchanged and the pointers both advance.
- Pointers wrap modulo DEPTH.
- Flush has priority over push, pop and handshake. On the next edge: count ← 0, pointers ← 0, wb_valid_o ← 0. wb_result_o/tag may keep stale data.
- Order: writeback order equals issue order, with no reordering.
- Reset values: count_o 0, issue_ready_o 1, alu_valid_o 0, alu_* 0, wb_valid_o 0, wb_result_o 0, wb_branch_res_o 0, wb_trans_id_o 0.
- Asserting rst_ni low mid-operation drops every in-flight entry immediately.

## Timing
- Empty pipeline: issue accepted at edge E0, alu_valid_o high in cycle after E0, capture at E1, wb_valid_o high after E1. Latency is 2 edges from acceptance to wb_valid_o.
- Sustained throughput is one operation per cycle while wb_ready_i = 1.
- With wb_ready_i held low, one result is held in the slot and the queue fills. Issue is blocked once DEPTH entries are queued, so DEPTH+1 operations are outstanding in total.
- When wb_ready_i rises on a full system, the slot handshake and the next capture occur on the same edge, with no bubble.
- The ALU path is combinational: queue head → ALU → wb register in one cycle. The block adds no extra register on the ALU side.

## Test plan
Benches drive the queue through a behavioural ALU model in which op ADD returns a+b and branch = (a==b).

- **Single ADD:** issue ADD, a=0x12345678, b=0x456789AB, tag 1, wb_ready_i=1 → wb_valid_o high exactly 2 edges after acceptance, wb_result_o=0x579BE023, wb_trans_id_o=1, wb_branch_res_o=0.
- **Back-to-back ordering:** issue tags 0..7 on consecutive cycles with wb_ready_i=1 → eight consecutive wb_valid_o cycles, tags 0..7 in order, correct sums. The pointer wrap is crossed twice.
- **Backpressure fill:** hold wb_ready_i=0 and issue 6 ops → issue_ready_o low after 5 accepted, count_o=4. Then raise wb_ready_i → results 0..4 drain one per cycle with no bubble, and op 5 is accepted the cycle after count_o drops below 4.
- **Simultaneous push/pop at full:** with count_o=DEPTH, issue_valid_i=1 and wb_ready_i=1 → no push that cycle, count_o goes to DEPTH-1, then the push is accepted next cycle.
- **Flush:** with 3 queued and wb_valid_o=1, assert flush_i together with issue_valid_i → next cycle count_o=0, wb_valid_o=0, the flush-cycle issue is not captured, and no stale tag is ever written back.
- **Reset mid-stream:** pulse rst_ni low asynchronously with 2 queued → outputs immediately at reset values. After release, a new ADD 1+1 with tag 5 → wb_result_o=2, tag 5.
